// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: machine width, reset vector, NOP encoding,
// fetch FSM encoding and a word-alignment helper.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR            = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FS_BOOT  = 2'd0,
      FS_FETCH = 2'd1,
      FS_FLUSH = 2'd2
   } fetch_state_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~{{(XLEN-2){1'b0}}, 2'b11};
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// In-order instruction buffer of {pc, instr}; the PC of each granted read waits in
// a side queue until its data returns. Flush wins over push and pop.
module fetch_buffer
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            req_push,
   input  logic [XLEN-1:0] req_pc,
   input  logic            push,
   input  logic [XLEN-1:0] push_instr,
   input  logic            pop,
   output logic [XLEN-1:0] head_instr,
   output logic [XLEN-1:0] head_pc,
   output logic [CW-1:0]   count,
   output logic            full,
   output logic            empty
);

   logic [XLEN-1:0] instr_mem [DEPTH];
   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] pcq_mem   [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   pcq_wr;
   logic [AW-1:0]   pcq_rd;
   logic [CW-1:0]   cnt;
   logic            do_push;
   logic            do_pop;

   assign empty      = (cnt == '0);
   assign full       = (cnt == CW'(DEPTH));
   assign do_pop     = pop && !empty;
   assign do_push    = push && (!full || do_pop);
   assign count      = cnt;
   assign head_instr = instr_mem[rd_ptr];
   assign head_pc    = pc_mem[rd_ptr];

   // Requested-PC queue: written on grant, consumed when the matching data arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcq_wr <= '0;
         pcq_rd <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pcq_mem[i] <= '0;
         end
      end else if (flush) begin
         pcq_wr <= '0;
         pcq_rd <= '0;
      end else begin
         if (req_push) begin
            pcq_mem[pcq_wr] <= req_pc;
            pcq_wr          <= pcq_wr + 1'b1;
         end
         if (do_push) begin
            pcq_rd <= pcq_rd + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            instr_mem[i] <= '0;
            pc_mem[i]    <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            instr_mem[wr_ptr] <= push_instr;
            pc_mem[wr_ptr]    <= pcq_mem[pcq_rd];
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC ownership, instruction-memory reads, in-order buffering
// and redirect flushing. Optional `FETCH_MISALIGN_CHECK_EN adds fetch_misaligned.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
   parameter int unsigned     BUF_DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic            fetch_misaligned
`endif
);

   localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

   localparam logic [1:0] BOOT  = FS_BOOT;
   localparam logic [1:0] FETCH = FS_FETCH;
   localparam logic [1:0] FLUSH = FS_FLUSH;

   if (BUF_DEPTH != 2 && BUF_DEPTH != 4) begin : g_bad_depth
      $error("instr_fetch: BUF_DEPTH must be 2 or 4");
   end

   logic [1:0]      state;
   logic [1:0]      state_next;
   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0]   out_cnt;
   logic [CW-1:0]   out_next;
   logic [CW-1:0]   buf_count;
   logic [CW:0]     inflight;
   logic            buf_full;
   logic            buf_empty;
   logic            grant;
   logic            rsp;
   logic            keep;
   logic            pop;

   assign imem_addr = fetch_pc;
   assign id_valid  = !buf_empty;
   assign pop       = id_valid && id_ready && !redirect;
   assign grant     = imem_req && imem_gnt;
   assign rsp       = imem_rvalid && (out_cnt != '0);
   assign keep      = rsp && (state == FETCH) && !redirect;
   assign out_next  = out_cnt + CW'(grant) - CW'(rsp);

   // A slot freed by this cycle's pop is counted as free already: its replacement
   // cannot return before next cycle, and this keeps 1 instr/cycle at depth 2.
   assign inflight  = {1'b0, out_cnt} + {1'b0, buf_count} - (CW+1)'(pop);
   assign imem_req  = (state == FETCH) && !redirect
                      && (inflight < (CW+1)'(BUF_DEPTH)) && !(buf_full && !pop);

   always_comb begin
      state_next = state;
      case (state)
         BOOT:    state_next = FETCH;
         FETCH:   state_next = FETCH;
         FLUSH:   if (out_next == '0) state_next = FETCH;
         default: state_next = BOOT;
      endcase
      if (redirect) begin
         state_next = (out_next != '0) ? FLUSH : FETCH;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= BOOT;
         out_cnt  <= '0;
         fetch_pc <= RESET_VECTOR;
      end else begin
         state   <= state_next;
         out_cnt <= out_next;
         if (redirect) begin
            fetch_pc <= word_align(redirect_pc);
         end else if (grant) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_misaligned <= 1'b0;
      end else begin
         fetch_misaligned <= redirect && (redirect_pc[1:0] != 2'b00);
      end
   end
`endif

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect),
      .req_push   (grant),
      .req_pc     (fetch_pc),
      .push       (keep),
      .push_instr (imem_rdata),
      .pop        (pop),
      .head_instr (id_instr),
      .head_pc    (id_pc),
      .count      (buf_count),
      .full       (buf_full),
      .empty      (buf_empty)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: an in-order memory model feeds responses and the
// expected {pc, instr} stream is rebuilt from a bench-side PC/credit model.
module tb_instr_fetch;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RV    = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        fetch_misaligned;
`endif

   always #5 clk = ~clk;

   instr_fetch #(
      .RESET_VECTOR (RV),
      .BUF_DEPTH    (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_instr    (id_instr),
      .id_pc       (id_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .fetch_misaligned (fetch_misaligned)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int unsigned epoch;
      int unsigned due;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   req_t        pend[$];
   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;
   int unsigned epoch  = 0;
   logic [31:0] exp_pc;
   bit          boot;
   bit          mis_exp;
   bit          rdy, redir, gnt_en, rsp_en;
   logic [31:0] rpc;
   logic        obs_req, obs_valid, obs_mis;
   logic [31:0] obs_addr, obs_pc, obs_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'd7) ^ 32'h0000_0013;
   endfunction

   // One clock: drive at negedge, observe settled outputs, then advance the model
   // exactly as the coming rising edge should.
   task automatic cycle();
      bit   rv, pop, stale, exp_req;
      int   used;
      req_t r;
      rv = rsp_en && (pend.size() != 0) && (pend[0].due <= cyc);
      id_ready    = rdy;
      redirect    = redir;
      redirect_pc = rpc;
      imem_gnt    = gnt_en;
      imem_rvalid = rv;
      imem_rdata  = rv ? mem_word(pend[0].addr) : 32'hDEAD_BEEF;
      #1;
      obs_req   = imem_req;
      obs_addr  = imem_addr;
      obs_valid = id_valid;
      obs_pc    = id_pc;
      obs_instr = id_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
      obs_mis = fetch_misaligned;
      checks++;
      if (obs_mis !== mis_exp) begin
         errors++;
         $display("FAIL misaligned cyc %0d: got %b expected %b", cyc, obs_mis, mis_exp);
      end
`else
      obs_mis = 1'b0;
`endif
      stale = 0;
      foreach (pend[i]) if (pend[i].epoch != epoch) stale = 1;
      pop     = (sb.size() != 0) && rdy && !redir;
      used    = pend.size() + sb.size() - (pop ? 1 : 0);
      exp_req = !boot && !redir && !stale && (used < DEPTH);
      checks++;
      if (obs_req !== exp_req) begin
         errors++;
         $display("FAIL imem_req cyc %0d: got %b expected %b", cyc, obs_req, exp_req);
      end
      if (obs_req) begin
         checks++;
         if (obs_addr !== exp_pc) begin
            errors++;
            $display("FAIL imem_addr cyc %0d: got %h expected %h", cyc, obs_addr, exp_pc);
         end
      end
      checks++;
      if (obs_valid !== (sb.size() != 0)) begin
         errors++;
         $display("FAIL id_valid cyc %0d: got %b expected %b", cyc, obs_valid, sb.size() != 0);
      end
      if (sb.size() != 0) begin
         checks++;
         if (obs_pc !== sb[0].pc || obs_instr !== sb[0].instr) begin
            errors++;
            $display("FAIL id_head cyc %0d: got pc %h instr %h expected pc %h instr %h",
                     cyc, obs_pc, obs_instr, sb[0].pc, sb[0].instr);
         end
      end
      if (rv) begin
         r = pend.pop_front();
         if (!redir && r.epoch == epoch) sb.push_back('{pc: r.addr, instr: mem_word(r.addr)});
      end
      if (pop) void'(sb.pop_front());
      if (obs_req && gnt_en) begin
         pend.push_back('{addr: exp_pc, epoch: epoch, due: cyc + 1});
         exp_pc = exp_pc + 32'd4;
      end
      if (redir) begin
         sb.delete();
         epoch++;
         exp_pc = rpc & ~32'h3;
      end
      mis_exp = redir && (rpc[1:0] != 2'b00);
      boot    = 0;
      cyc++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      redirect = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0; id_ready = 1'b0;
      redirect_pc = '0; imem_rdata = '0;
      rdy = 0; redir = 0; rpc = '0; gnt_en = 1; rsp_en = 1;
      pend.delete(); sb.delete();
      exp_pc = RV; boot = 1; mis_exp = 0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: got req %b valid %b instr %h pc %h expected 0 0 0 0",
                  imem_req, id_valid, id_instr, id_pc);
      end
      checks++;
      if (imem_addr !== RV) begin
         errors++;
         $display("FAIL reset_addr: got %h expected %h", imem_addr, RV);
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      checks++;
      if (fetch_misaligned !== 1'b0) begin
         errors++;
         $display("FAIL reset_misaligned: got %b expected 0", fetch_misaligned);
      end
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rdy   = 1;
      cycle();
      checks++;
      if (obs_req !== 1'b0) begin
         errors++;
         $display("FAIL boot_no_req: got %b expected 0", obs_req);
      end
      cycle();
      checks++;
      if (obs_req !== 1'b1 || obs_addr !== RV) begin
         errors++;
         $display("FAIL first_req: got req %b addr %h expected 1 %h", obs_req, obs_addr, RV);
      end
   endtask

   task automatic test_stream();
      for (int k = 3; k <= 10; k++) begin
         cycle();
         if (k == 3 || k == 4) begin
            checks++;
            if (obs_addr !== RV + 32'(4 * (k - 2))) begin
               errors++;
               $display("FAIL stream_addr k%0d: got %h expected %h", k, obs_addr, RV + 32'(4 * (k - 2)));
            end
         end
         if (k >= 4 && k <= 6) begin
            checks++;
            if (obs_valid !== 1'b1 || obs_pc !== RV + 32'(4 * (k - 4))) begin
               errors++;
               $display("FAIL stream_pc k%0d: got valid %b pc %h expected 1 %h",
                        k, obs_valid, obs_pc, RV + 32'(4 * (k - 4)));
            end
         end
      end
   endtask

   task automatic test_stall();
      rdy = 0;
      for (int k = 0; k < 5; k++) cycle();
      checks++;
      if (obs_req !== 1'b0 || obs_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_hold: got req %b valid %b expected 0 1", obs_req, obs_valid);
      end
      rdy = 1;
      for (int k = 0; k < 6; k++) cycle();
   endtask

   task automatic test_redirect();
      bit seen;
      rsp_en = 0;
      for (int k = 0; k < 4; k++) cycle();
      redir = 1; rpc = 32'h0000_0100;
      cycle();
      redir = 0; rsp_en = 1;
      for (int k = 1; k <= 2; k++) begin
         cycle();
         checks++;
         if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_quiet %0d: got req %b valid %b expected 0 0", k, obs_req, obs_valid);
         end
      end
      cycle();
      checks++;
      if (obs_req !== 1'b1 || obs_addr !== 32'h0000_0100) begin
         errors++;
         $display("FAIL flush_restart: got req %b addr %h expected 1 00000100", obs_req, obs_addr);
      end
      seen = 0;
      for (int k = 0; k < 6 && !seen; k++) begin
         cycle();
         if (obs_valid) begin
            seen = 1;
            checks++;
            if (obs_pc !== 32'h0000_0100) begin
               errors++;
               $display("FAIL redirect_first_pc: got %h expected 00000100", obs_pc);
            end
         end
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL redirect_timeout: got no id_valid expected one within 6 cycles");
      end
   endtask

   task automatic test_redirect_collide();
      for (int k = 0; k < 3; k++) cycle();
      redir = 1; rpc = 32'h0000_0200;
      cycle();
      checks++;
      if (obs_valid !== 1'b1) begin
         errors++;
         $display("FAIL collide_setup: got valid %b expected 1", obs_valid);
      end
      redir = 0;
      cycle();
      checks++;
      if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h0000_0200) begin
         errors++;
         $display("FAIL collide_after: got valid %b req %b addr %h expected 0 1 00000200",
                  obs_valid, obs_req, obs_addr);
      end
      for (int k = 0; k < 4; k++) cycle();
   endtask

   task automatic test_wrap();
      bit saw_top, wrapped;
      redir = 1; rpc = 32'hFFFF_FFF8;
      cycle();
      redir = 0;
      saw_top = 0; wrapped = 0;
      for (int k = 0; k < 12 && !wrapped; k++) begin
         cycle();
         if (obs_req && gnt_en) begin
            if (saw_top) begin
               wrapped = 1;
               checks++;
               if (obs_addr !== 32'h0) begin
                  errors++;
                  $display("FAIL wrap_addr: got %h expected 00000000", obs_addr);
               end
            end
            saw_top = (obs_addr == 32'hFFFF_FFFC);
         end
      end
      if (!wrapped) begin
         checks++; errors++;
         $display("FAIL wrap_timeout: got no grant after FFFFFFFC expected one within 12 cycles");
      end
      for (int k = 0; k < 4; k++) cycle();
   endtask

`ifdef FETCH_MISALIGN_CHECK_EN
   task automatic test_misalign();
      bit seen;
      redir = 1; rpc = 32'h0000_0102;
      cycle();
      redir = 0;
      cycle();
      checks++;
      if (obs_mis !== 1'b1) begin
         errors++;
         $display("FAIL misalign_pulse: got %b expected 1", obs_mis);
      end
      seen = 0;
      for (int k = 0; k < 6 && !seen; k++) begin
         cycle();
         if (k == 0) begin
            checks++;
            if (obs_mis !== 1'b0) begin
               errors++;
               $display("FAIL misalign_clear: got %b expected 0", obs_mis);
            end
         end
         if (obs_req) begin
            seen = 1;
            checks++;
            if (obs_addr !== 32'h0000_0100) begin
               errors++;
               $display("FAIL misalign_addr: got %h expected 00000100", obs_addr);
            end
         end
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL misalign_timeout: got no imem_req expected one within 6 cycles");
      end
      for (int k = 0; k < 4; k++) cycle();
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_collide();
      test_wrap();
`ifdef FETCH_MISALIGN_CHECK_EN
      test_misalign();
`endif
      test_reset();
      test_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
